// File: rtl/pipe_flow_ctrl.sv
// Central pipeline hazard controller: per-stage WORK/STOP/REFRESH flow codes resolved by priority.
// Optional performance counters are enabled with `define FLOW_CTRL_PERF_EN.

`ifndef FLOW_WIDTH
`define FLOW_WIDTH 2
`endif
`ifndef FLOW_WORK
`define FLOW_WORK 2'b00
`endif
`ifndef FLOW_STOP
`define FLOW_STOP 2'b01
`endif
`ifndef FLOW_REFRESH
`define FLOW_REFRESH 2'b10
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module pipe_flow_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned TRAP_FLUSH_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ex_is_load_i,
    input  logic [`REG_ADDR_WIDTH-1:0] ex_rd_addr_i,
    input  logic [`REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
    input  logic [`REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
    input  logic                       id_rs1_used_i,
    input  logic                       id_rs2_used_i,
    input  logic                       ex_redirect_i,
    input  logic                       muldiv_start_i,
    input  logic                       muldiv_done_i,
    input  logic                       mem_busy_i,
    input  logic                       trap_i,
    output logic                       muldiv_kill_o,
    output logic [`FLOW_WIDTH-1:0]     flow_pc_o,
    output logic [`FLOW_WIDTH-1:0]     flow_if_id_o,
    output logic [`FLOW_WIDTH-1:0]     flow_id_ex_o,
    output logic [`FLOW_WIDTH-1:0]     flow_ex_mem_o,
    output logic [`FLOW_WIDTH-1:0]     flow_mem_wb_o,
    output logic [31:0]                perf_stall_o,
    output logic [31:0]                perf_flush_o
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_MDWAIT  = 2'd2,
        ST_FLUSH   = 2'd3
    } state_e;

    localparam logic [`FLOW_WIDTH-1:0] W = `FLOW_WORK;
    localparam logic [`FLOW_WIDTH-1:0] S = `FLOW_STOP;
    localparam logic [`FLOW_WIDTH-1:0] R = `FLOW_REFRESH;

    localparam logic [2:0] LD_RELOAD   = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [2:0] TRAP_RELOAD = 3'(TRAP_FLUSH_CYCLES - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       load_use;

    assign load_use = ex_is_load_i && (ex_rd_addr_i != '0) &&
                      ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                       (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i)));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FLUSH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output and next-state value gets a default first, so no path infers a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        muldiv_kill_o = 1'b0;
        {flow_pc_o, flow_if_id_o, flow_id_ex_o, flow_ex_mem_o, flow_mem_wb_o} = {W, W, W, W, W};

        if (!rst_n) begin
            {flow_pc_o, flow_if_id_o, flow_id_ex_o, flow_ex_mem_o, flow_mem_wb_o} = {R, R, R, R, R};
        end else if (trap_i) begin
            {flow_pc_o, flow_if_id_o, flow_id_ex_o, flow_ex_mem_o, flow_mem_wb_o} = {W, R, R, R, W};
            muldiv_kill_o = (state_q == ST_MDWAIT) || muldiv_start_i;
            // The trap cycle itself is the first refresh cycle.
            if (TRAP_FLUSH_CYCLES > 1) begin
                state_d = ST_FLUSH;
                cnt_d   = TRAP_RELOAD;
            end else begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end else if (mem_busy_i) begin
            {flow_pc_o, flow_if_id_o, flow_id_ex_o, flow_ex_mem_o, flow_mem_wb_o} = {S, S, S, S, S};
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (ex_redirect_i) begin
                        {flow_pc_o, flow_if_id_o, flow_id_ex_o, flow_ex_mem_o, flow_mem_wb_o} = {W, R, R, W, W};
                    end else if (muldiv_start_i) begin
                        if (!muldiv_done_i) begin
                            {flow_pc_o, flow_if_id_o, flow_id_ex_o, flow_ex_mem_o, flow_mem_wb_o} = {S, S, S, R, W};
                            state_d = ST_MDWAIT;
                        end
                    end else if (load_use) begin
                        {flow_pc_o, flow_if_id_o, flow_id_ex_o, flow_ex_mem_o, flow_mem_wb_o} = {S, S, R, W, W};
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = ST_LDSTALL;
                            cnt_d   = LD_RELOAD;
                        end
                    end
                end
                ST_LDSTALL: begin
                    {flow_pc_o, flow_if_id_o, flow_id_ex_o, flow_ex_mem_o, flow_mem_wb_o} = {S, S, R, W, W};
                    if (cnt_q <= 3'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                ST_MDWAIT: begin
                    if (muldiv_done_i) begin
                        state_d = ST_RUN;
                    end else begin
                        {flow_pc_o, flow_if_id_o, flow_id_ex_o, flow_ex_mem_o, flow_mem_wb_o} = {S, S, S, R, W};
                    end
                end
                ST_FLUSH: begin
                    {flow_pc_o, flow_if_id_o, flow_id_ex_o, flow_ex_mem_o, flow_mem_wb_o} = {W, R, R, R, W};
                    if (cnt_q <= 3'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef FLOW_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (flow_pc_o == S) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (trap_i || (ex_redirect_i && !mem_busy_i)) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign perf_stall_o = stall_cnt_q;
    assign perf_flush_o = flush_cnt_q;
`else
    assign perf_stall_o = 32'd0;
    assign perf_flush_o = 32'd0;
`endif

endmodule
